// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, tables and types shared by the hyperbolic CORDIC units
// (exp_x and its natural-log partner). All fixed-point constants are signed Q4.20.
package cordic_pkg;

    localparam int TBL_W = 24;

    // Bus-select codes on the shared `func` input
    localparam logic [3:0] FUNC_LN  = 4'd8;
    localparam logic [3:0] FUNC_EXP = 4'd9;

    // 1/K_h = 1.2074970677, pre-scales x so the final x+y needs no gain correction
    localparam logic signed [TBL_W-1:0] INV_KH = 24'sd1266152;

    // ln2 = 0.6931471806
    localparam logic signed [TBL_W-1:0] LN2 = 24'sd726817;

    // Smallest Q4.20 values strictly above 0.5*ln2, 1.5*ln2 and 2.5*ln2; used to
    // form k = round(x/ln2) without a divider. Q2.14 inputs can never hit a tie.
    localparam logic signed [TBL_W-1:0] KTH0 = 24'sd363409;
    localparam logic signed [TBL_W-1:0] KTH1 = 24'sd1090227;
    localparam logic signed [TBL_W-1:0] KTH2 = 24'sd1817044;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FINISH,
        S_DONE
    } state_e;

    // atanh(2^-i) for i = 1..16, rounded to nearest.
    // NOTE: a constant case table becomes plain logic, not storage, so there is nothing to reset.
    function automatic logic signed [TBL_W-1:0] atanh_lut(input logic [4:0] idx);
        case (idx)
            5'd1:    return 24'sd575989;
            5'd2:    return 24'sd267820;
            5'd3:    return 24'sd131761;
            5'd4:    return 24'sd65622;
            5'd5:    return 24'sd32779;
            5'd6:    return 24'sd16385;
            5'd7:    return 24'sd8192;
            5'd8:    return 24'sd4096;
            5'd9:    return 24'sd2048;
            5'd10:   return 24'sd1024;
            5'd11:   return 24'sd512;
            5'd12:   return 24'sd256;
            5'd13:   return 24'sd128;
            5'd14:   return 24'sd64;
            5'd15:   return 24'sd32;
            5'd16:   return 24'sd16;
            default: return 24'sd0;
        endcase
    endfunction

    // k*ln2 for k = -3..3, each product rounded to nearest
    function automatic logic signed [TBL_W-1:0] kln2_lut(input logic signed [2:0] k);
        case (k)
            3'sd1:   return 24'sd726817;
            3'sd2:   return 24'sd1453635;
            3'sd3:   return 24'sd2180452;
            -3'sd1:  return -24'sd726817;
            -3'sd2:  return -24'sd1453635;
            -3'sd3:  return -24'sd2180452;
            default: return 24'sd0;
        endcase
    endfunction

endpackage

// File: rtl/cordic_hyp_step.sv
// cordic_hyp_step: one combinational hyperbolic CORDIC micro-rotation, rotation
// direction taken from the sign of z. Shared with the log unit.
module cordic_hyp_step
    import cordic_pkg::*;
#(
    parameter int DW = 24
) (
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] y_i,
    input  logic signed [DW-1:0] z_i,
    input  logic        [4:0]    shift_i,
    input  logic signed [DW-1:0] atanh_i,
    output logic signed [DW-1:0] x_o,
    output logic signed [DW-1:0] y_o,
    output logic signed [DW-1:0] z_o
);

    logic signed [DW-1:0] x_sh;
    logic signed [DW-1:0] y_sh;

    // Rotate towards z = 0: d = +1 when z >= 0, else -1; all terms use the old x/y/z
    always_comb begin
        // NOTE: every output gets a default first so no path can leave a latch behind.
        x_o  = x_i;
        y_o  = y_i;
        z_o  = z_i;
        x_sh = x_i >>> shift_i;
        y_sh = y_i >>> shift_i;
        if (!z_i[DW-1]) begin
            x_o = x_i + y_sh;
            y_o = y_i + x_sh;
            z_o = z_i - atanh_i;
        end else begin
            x_o = x_i - y_sh;
            y_o = y_i - x_sh;
            z_o = z_i + atanh_i;
        end
    end

endmodule

// File: rtl/exp_x.sv
// exp_x: e^x by hyperbolic CORDIC in rotation mode, one micro-rotation per clock.
// x is Q2.14, the datapath is Q4.20, the result is Q16.16 on a tri-stated bus
// shared with the log unit.
// Optional build macro: EXP_RANGE_REDUCE_EN -- reduces x by k*ln2 so the whole
// Q2.14 span is valid; without it |x| > 1.0 raises err and returns 0.
module exp_x
    import cordic_pkg::*;
#(
    parameter int         ITER      = 16,
    parameter int         DW        = 24,
    parameter logic [3:0] FUNC_CODE = FUNC_EXP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st,
    input  logic [15:0] x,
    input  logic [3:0]  func,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e               state_q, state_d;
    logic [15:0]          xin_q, xin_d;
    logic signed [DW-1:0] x_q, x_d;
    logic signed [DW-1:0] y_q, y_d;
    logic signed [DW-1:0] z_q, z_d;
    logic [4:0]           idx_q, idx_d;
    logic                 rep_q, rep_d;
    logic [31:0]          res_q, res_d;
    logic                 err_q, err_d;

    logic signed [DW-1:0] x_nx, y_nx, z_nx;
    logic signed [DW-1:0] atanh_c;
    logic signed [DW-1:0] x_ext;
    logic signed [DW-1:0] z_init;
    logic signed [DW-1:0] s_sum;
    logic signed [31:0]   s_wide;
    logic signed [31:0]   s_scaled;
    logic                 op_err;
    logic                 last_step;

`ifdef EXP_RANGE_REDUCE_EN
    logic signed [2:0]    k_q, k_d;
    logic signed [2:0]    k_load;
`endif

    // Captured Q2.14 operand re-expressed in Q4.20
    assign x_ext   = DW'($signed(xin_q)) <<< 6;
    assign atanh_c = DW'(atanh_lut(idx_q));

`ifdef EXP_RANGE_REDUCE_EN
    // Choose k = round(x/ln2) by threshold compares and start CORDIC on r = x - k*ln2
    always_comb begin
        if (x_ext >= DW'(KTH2))       k_load = 3'sd3;
        else if (x_ext >= DW'(KTH1))  k_load = 3'sd2;
        else if (x_ext >= DW'(KTH0))  k_load = 3'sd1;
        else if (x_ext > -DW'(KTH0))  k_load = 3'sd0;
        else if (x_ext > -DW'(KTH1))  k_load = -3'sd1;
        else if (x_ext > -DW'(KTH2))  k_load = -3'sd2;
        else                          k_load = -3'sd3;
        z_init = x_ext - DW'(kln2_lut(k_load));
    end

    assign op_err = 1'b0;
`else
    assign z_init = x_ext;
    // Without reduction only |x| <= 1.0 is inside the convergence range
    assign op_err = ($signed(xin_q) < -16'sd16384) || ($signed(xin_q) > 16'sd16384);
`endif

    // Final sum cosh+sinh, undo the 2^k scaling if any, then align Q4.20 to Q16.16
    always_comb begin
        s_sum  = x_q + y_q;
        s_wide = 32'(s_sum);
`ifdef EXP_RANGE_REDUCE_EN
        if (k_q < 0) s_scaled = s_wide >>> unsigned'(-k_q);
        else         s_scaled = s_wide <<< unsigned'(k_q);
`else
        s_scaled = s_wide;
`endif
    end

    cordic_hyp_step #(
        .DW(DW)
    ) u_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .z_i    (z_q),
        .shift_i(idx_q),
        .atanh_i(atanh_c),
        .x_o    (x_nx),
        .y_o    (y_nx),
        .z_o    (z_nx)
    );

    // The final index (and its repeat, when it is 4 or 13) ends the rotation phase
    assign last_step = (idx_q == 5'(ITER)) &&
                       !(((idx_q == 5'd4) || (idx_q == 5'd13)) && !rep_q);

    // Sequencer: next state and next datapath values, holding everything by default
    always_comb begin
        state_d = state_q;
        xin_d   = xin_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef EXP_RANGE_REDUCE_EN
        k_d     = k_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (st) begin
                    xin_d   = x;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                x_d     = DW'(INV_KH);
                y_d     = '0;
                z_d     = z_init;
                idx_d   = 5'd1;
                rep_d   = 1'b0;
`ifdef EXP_RANGE_REDUCE_EN
                k_d     = k_load;
`endif
                state_d = S_ITER;
            end
            S_ITER: begin
                x_d = x_nx;
                y_d = y_nx;
                z_d = z_nx;
                if (((idx_q == 5'd4) || (idx_q == 5'd13)) && !rep_q) begin
                    // Hold the index for one extra pass to keep convergence
                    rep_d = 1'b1;
                end else begin
                    rep_d = 1'b0;
                    idx_d = idx_q + 5'd1;
                end
                if (last_step) state_d = S_FINISH;
            end
            S_FINISH: begin
                res_d   = op_err ? 32'd0 : 32'(s_scaled >>> 4);
                err_d   = op_err;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset so an aborted run leaves nothing behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            xin_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            idx_q   <= '0;
            rep_q   <= 1'b0;
            res_q   <= '0;
            err_q   <= 1'b0;
`ifdef EXP_RANGE_REDUCE_EN
            k_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            xin_q   <= xin_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            res_q   <= res_d;
            err_q   <= err_d;
`ifdef EXP_RANGE_REDUCE_EN
            k_q     <= k_d;
`endif
        end
    end

    assign busy   = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_FINISH);
    assign done   = (state_q == S_DONE);
    assign err    = err_q;
    assign result = (func == FUNC_CODE) ? res_q : 'z;

endmodule
